// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative WIDTH-bit multiply/divide unit with HI/LO result registers.
// One shift-add or restoring shift-subtract step per cycle on operand magnitudes, sign fix-up at the end.
`default_nettype none

module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             HiWrite,
  input  logic             LoWrite,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]    count;
  logic             is_div;
  logic             neg_result;
  logic             neg_rem;
  logic             div_zero;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] product_neg;

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = RUN;
      RUN:     if (count == LAST_STEP) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign Busy = (state != IDLE);

  // Op[0]=0 selects the signed variants (MULT/DIV).
  assign a_neg = ~Op[0] & OperandA[WIDTH-1];
  assign b_neg = ~Op[0] & OperandB[WIDTH-1];
  assign a_mag = a_neg ? -OperandA : OperandA;
  assign b_mag = b_neg ? -OperandB : OperandB;

  // acc_lo holds the multiplier (mul) or the dividend being shifted into the remainder (div).
  assign mul_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
  assign div_trial   = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, opb};
  assign product     = {acc_hi, acc_lo};
  assign product_neg = -product;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count      <= '0;
      is_div     <= 1'b0;
      neg_result <= 1'b0;
      neg_rem    <= 1'b0;
      div_zero   <= 1'b0;
      opb        <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      Hi         <= '0;
      Lo         <= '0;
      Done       <= 1'b0;
      DivByZero  <= 1'b0;
    end else begin
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      case (state)
        IDLE: begin
          if (HiWrite) Hi <= OperandA;
          if (LoWrite) Lo <= OperandA;
          if (Start) begin
            is_div     <= Op[1];
            neg_result <= a_neg ^ b_neg;
            neg_rem    <= a_neg;
            div_zero   <= Op[1] & (OperandB == '0);
            opb        <= b_mag;
            acc_hi     <= '0;
            acc_lo     <= a_mag;
            count      <= '0;
          end
        end
        RUN: begin
          count <= count + 1'b1;
          if (is_div) begin
            // A clear MSB on the trial subtraction means the divisor fit.
            if (!div_trial[WIDTH]) begin
              acc_hi <= div_trial[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          Done      <= 1'b1;
          DivByZero <= div_zero;
          if (is_div) begin
            // A zero divisor leaves the dividend magnitude as remainder, so the sign fix restores OperandA.
            Hi <= neg_rem ? -acc_hi : acc_hi;
            if (div_zero)        Lo <= '1;
            else if (neg_result) Lo <= -acc_lo;
            else                 Lo <= acc_lo;
          end else begin
            {Hi, Lo} <= neg_result ? product_neg : product;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
